// File: rtl/bwt_req_pkg.sv
// Shared definitions for the BWT request issue queue: default widths, K/L tag
// encodings, issue FSM states and the buffered request-entry layout.
package bwt_req_pkg;

    localparam int ADDR_W_DEF         = 42;
    localparam int READ_NUM_WIDTH_DEF = 9;

    localparam logic [1:0] KL_K    = 2'b01;
    localparam logic [1:0] KL_L    = 2'b10;
    localparam logic [1:0] KL_BOTH = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_K = 2'd1,
        SEND_L = 2'd2
    } state_t;

    typedef struct packed {
        logic [READ_NUM_WIDTH_DEF-1:0] read_num;
        logic [ADDR_W_DEF-1:0]         addr_k;
        logic [ADDR_W_DEF-1:0]         addr_l;
    } req_entry_t;

endpackage

// File: rtl/bwt_req_fifo.sv
// Synchronous FIFO with occupancy count; a push is accepted while full when a
// pop happens in the same cycle. Drops set a sticky overflow flag.
module bwt_req_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_req,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] rd_data_next,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    count_next,
    output logic             overflow_err
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;

    assign push = push_req && ((count != CW'(DEPTH)) || pop);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    assign rd_data = mem[rd_ptr];
    // The entry behind the head may still be on the write port when only one is stored.
    assign rd_data_next = (count > CW'(1)) ? mem[rd_ptr + AW'(1)] : wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            if (push_req && !push) overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/bwt_req_issue_queue.sv
// Buffers CAL_KL requests and serialises each into K then L cache-line reads.
// Define BWT_REQ_MERGE_SAME_LINE_EN to issue a single KL_BOTH read when addr_k == addr_l.
module bwt_req_issue_queue
    import bwt_req_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int READ_NUM_WIDTH = READ_NUM_WIDTH_DEF,
    parameter int STALL_MARGIN   = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        request_valid,
    input  logic [ADDR_W-1:0]           addr_k,
    input  logic [ADDR_W-1:0]           addr_l,
    input  logic [READ_NUM_WIDTH-1:0]   read_num,
    output logic                        stall_out,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [ADDR_W-1:0]           mem_req_addr,
    output logic [READ_NUM_WIDTH+1:0]   mem_req_tag,
    output logic [$clog2(DEPTH):0]      fill_level,
    output logic                        overflow_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = READ_NUM_WIDTH + 2 * ADDR_W;
    localparam logic [31:0] DEPTH_U  = 32'(DEPTH);
    localparam logic [31:0] MARGIN_U = 32'(STALL_MARGIN);

    // mem_req_valid/ready: a beat transfers on a cycle where both are high; while
    // valid is high and ready is low, addr and tag hold, and valid only drops
    // after a transfer (or on rst).

    state_t state;
    state_t next_state;

    logic [EW-1:0] wr_data, head, head_next;
    logic [CW-1:0] count, count_next;
    logic          pop;

    logic [READ_NUM_WIDTH-1:0] head_rn, next_rn;
    logic [ADDR_W-1:0]         head_k, head_l, next_k;
    logic                      head_merge, next_merge;

    logic                      load;
    logic                      clear_valid;
    logic [ADDR_W-1:0]         load_addr;
    logic [1:0]                load_kl;
    logic [READ_NUM_WIDTH-1:0] load_rn;

    assign wr_data = {read_num, addr_k, addr_l};

    bwt_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_req     (request_valid),
        .wr_data      (wr_data),
        .pop          (pop),
        .rd_data      (head),
        .rd_data_next (head_next),
        .count        (count),
        .count_next   (count_next),
        .overflow_err (overflow_err)
    );

    assign head_rn = head[EW-1 -: READ_NUM_WIDTH];
    assign head_k  = head[2*ADDR_W-1 -: ADDR_W];
    assign head_l  = head[ADDR_W-1:0];
    assign next_rn = head_next[EW-1 -: READ_NUM_WIDTH];
    assign next_k  = head_next[2*ADDR_W-1 -: ADDR_W];

`ifdef BWT_REQ_MERGE_SAME_LINE_EN
    assign head_merge = (head_k == head_l);
    assign next_merge = (next_k == head_next[ADDR_W-1:0]);
`else
    assign head_merge = 1'b0;
    assign next_merge = 1'b0;
`endif

    // A merged entry goes straight to SEND_L: its single handshake pops it.
    always_comb begin
        next_state  = state;
        pop         = 1'b0;
        load        = 1'b0;
        clear_valid = 1'b0;
        load_addr   = '0;
        load_kl     = KL_K;
        load_rn     = '0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    load       = 1'b1;
                    load_rn    = head_rn;
                    load_addr  = head_k;
                    load_kl    = head_merge ? KL_BOTH : KL_K;
                    next_state = head_merge ? SEND_L : SEND_K;
                end
            end
            SEND_K: begin
                if (mem_req_ready) begin
                    load       = 1'b1;
                    load_rn    = head_rn;
                    load_addr  = head_l;
                    load_kl    = KL_L;
                    next_state = SEND_L;
                end
            end
            SEND_L: begin
                if (mem_req_ready) begin
                    pop = 1'b1;
                    // A push is always accepted alongside a pop, so it counts as a next entry.
                    if ((count > CW'(1)) || request_valid) begin
                        load       = 1'b1;
                        load_rn    = next_rn;
                        load_addr  = next_k;
                        load_kl    = next_merge ? KL_BOTH : KL_K;
                        next_state = next_merge ? SEND_L : SEND_K;
                    end else begin
                        clear_valid = 1'b1;
                        next_state  = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_tag   <= '0;
            stall_out     <= 1'b0;
        end else begin
            state <= next_state;
            if (load) begin
                mem_req_valid <= 1'b1;
                mem_req_addr  <= load_addr;
                mem_req_tag   <= {load_rn, load_kl};
            end else if (clear_valid) begin
                mem_req_valid <= 1'b0;
            end
            stall_out <= (DEPTH_U - 32'(count_next)) <= MARGIN_U;
        end
    end

    assign fill_level = count;

endmodule
